// File: rtl/csr_regfile.sv
// Machine-mode CSR storage for the Balotelli core.
// Holds mstatus, mie, mtvec, mscratch, mepc, mcause, mip, mcycle and minstret,
// and answers mhartid from a parameter. Two write ports feed the registers:
// the exception controller (Clint) and the pipeline write-back stage. On an
// address collision the Clint data wins. The pipeline read port sees
// write-first forwarding from the pipeline write port only.
module csr_regfile #(
   parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000,
   parameter logic [63:0] HART_ID   = 64'h0
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        CsrReadEnableIn,
   input  logic [11:0] CsrReadAddrIn,
   output logic [63:0] CsrReadDataOut,
   output logic        IllegalCsrOut,
   input  logic        CsrWriteEnableIn,
   input  logic [11:0] CsrWriteAddrIn,
   input  logic [63:0] CsrWriteDataIn,
   input  logic        ClintWriteEnableIn,
   input  logic [11:0] ClintWriteAddrIn,
   input  logic [63:0] ClintWriteDataIn,
   input  logic        InstRetireIn,
   input  logic        TimerIntIn,
   output logic [63:0] CsrMstatusReadDataOut,
   output logic [63:0] CsrMtvecReadDataOut,
   output logic [63:0] CsrMepcReadDataOut,
   output logic [63:0] CsrMieReadDataOut,
   output logic [63:0] CsrMipReadDataOut,
   output logic        IntAppearOut,
   output logic [5:0]  IntFlagOut
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0000_0088;
   localparam logic [63:0] MIE_MASK     = 64'h0000_0000_0000_0080;
   localparam logic [63:0] ALIGN_MASK   = ~64'h3;

   logic [63:0] mstatusReg;
   logic [63:0] mieReg;
   logic [63:0] mtvecReg;
   logic [63:0] mscratchReg;
   logic [63:0] mepcReg;
   logic [63:0] mcauseReg;
   logic        mipReg;
   logic [63:0] mcycleReg;
   logic [63:0] minstretReg;

   logic        pipeWriteValid;
   logic [63:0] pipeWriteData;
   logic [63:0] clintWriteData;
   logic        clintSetsMtip;
   logic        readImplemented;
   logic [63:0] readRegValue;
   logic        readForward;

   // Masks away the read-only-zero bits of a CSR before it is stored or forwarded.
   function automatic logic [63:0] applyFieldRules(input logic [11:0] addr, input logic [63:0] data);
      logic [63:0] result;
      result = data;
      case (addr)
         ADDR_MSTATUS: result = data & MSTATUS_MASK;
         ADDR_MIE:     result = data & MIE_MASK;
         ADDR_MTVEC:   result = data & ALIGN_MASK;
         ADDR_MEPC:    result = data & ALIGN_MASK;
         default:      result = data;
      endcase
      return result;
   endfunction

   // Resolves write-port priority: a pipeline write to the Clint's address this cycle is dropped.
   always_comb begin
      pipeWriteValid = CsrWriteEnableIn &&
                       !(ClintWriteEnableIn && (ClintWriteAddrIn == CsrWriteAddrIn));
      pipeWriteData  = applyFieldRules(CsrWriteAddrIn, CsrWriteDataIn);
      clintWriteData = applyFieldRules(ClintWriteAddrIn, ClintWriteDataIn);
      clintSetsMtip  = ClintWriteEnableIn && (ClintWriteAddrIn == ADDR_MIP) && ClintWriteDataIn[7];
   end

   // Register update: counters step first, then writes override their increment, and reset beats all.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         mstatusReg  <= 64'h0;
         mieReg      <= 64'h0;
         mtvecReg    <= MTVEC_RST;
         mscratchReg <= 64'h0;
         mepcReg     <= 64'h0;
         mcauseReg   <= 64'h0;
         mipReg      <= 1'b0;
         mcycleReg   <= 64'h0;
         minstretReg <= 64'h0;
      end else begin
         mcycleReg <= mcycleReg + 64'd1;
         if (InstRetireIn) begin
            minstretReg <= minstretReg + 64'd1;
         end
         if (pipeWriteValid) begin
            case (CsrWriteAddrIn)
               ADDR_MSTATUS:  mstatusReg  <= pipeWriteData;
               ADDR_MIE:      mieReg      <= pipeWriteData;
               ADDR_MTVEC:    mtvecReg    <= pipeWriteData;
               ADDR_MSCRATCH: mscratchReg <= pipeWriteData;
               ADDR_MEPC:     mepcReg     <= pipeWriteData;
               ADDR_MCAUSE:   mcauseReg   <= pipeWriteData;
               ADDR_MCYCLE:   mcycleReg   <= pipeWriteData;
               ADDR_MINSTRET: minstretReg <= pipeWriteData;
               default:       ;
            endcase
         end
         if (ClintWriteEnableIn) begin
            case (ClintWriteAddrIn)
               ADDR_MSTATUS:  mstatusReg  <= clintWriteData;
               ADDR_MIE:      mieReg      <= clintWriteData;
               ADDR_MTVEC:    mtvecReg    <= clintWriteData;
               ADDR_MSCRATCH: mscratchReg <= clintWriteData;
               ADDR_MEPC:     mepcReg     <= clintWriteData;
               ADDR_MCAUSE:   mcauseReg   <= clintWriteData;
               ADDR_MCYCLE:   mcycleReg   <= clintWriteData;
               ADDR_MINSTRET: minstretReg <= clintWriteData;
               default:       ;
            endcase
         end
         mipReg <= TimerIntIn | clintSetsMtip;
      end
   end

   // Pipeline read port with write-first forwarding from the pipeline write port.
   always_comb begin
      readImplemented = 1'b1;
      readRegValue    = 64'h0;
      case (CsrReadAddrIn)
         ADDR_MSTATUS:  readRegValue = mstatusReg;
         ADDR_MIE:      readRegValue = mieReg;
         ADDR_MTVEC:    readRegValue = mtvecReg;
         ADDR_MSCRATCH: readRegValue = mscratchReg;
         ADDR_MEPC:     readRegValue = mepcReg;
         ADDR_MCAUSE:   readRegValue = mcauseReg;
         ADDR_MIP:      readRegValue = {56'h0, mipReg, 7'h0};
         ADDR_MCYCLE:   readRegValue = mcycleReg;
         ADDR_MINSTRET: readRegValue = minstretReg;
         ADDR_MHARTID:  readRegValue = HART_ID;
         default:       readImplemented = 1'b0;
      endcase
      readForward = CsrWriteEnableIn && (CsrWriteAddrIn == CsrReadAddrIn) && readImplemented &&
                    (CsrReadAddrIn != ADDR_MHARTID) && (CsrReadAddrIn != ADDR_MIP);
      CsrReadDataOut = readForward ? pipeWriteData : readRegValue;
      IllegalCsrOut  = CsrReadEnableIn && !readImplemented;
   end

   // Dedicated controller buses and the interrupt request come straight from the registers.
   always_comb begin
      CsrMstatusReadDataOut = mstatusReg;
      CsrMtvecReadDataOut   = mtvecReg;
      CsrMepcReadDataOut    = mepcReg;
      CsrMieReadDataOut     = mieReg;
      CsrMipReadDataOut     = {56'h0, mipReg, 7'h0};
      IntAppearOut          = mipReg & mieReg[7];
      IntFlagOut            = IntAppearOut ? 6'h08 : 6'h00;
   end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed trap/collision/forward/timer/counter
// scenarios followed by randomized traffic, all compared against a CSR-map model.
module tb_csr_regfile;

   localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000;
   localparam logic [63:0] HART_ID   = 64'h0000_0000_0000_0003;

   logic        Clk;
   logic        Rst;
   logic        CsrReadEnableIn;
   logic [11:0] CsrReadAddrIn;
   logic [63:0] CsrReadDataOut;
   logic        IllegalCsrOut;
   logic        CsrWriteEnableIn;
   logic [11:0] CsrWriteAddrIn;
   logic [63:0] CsrWriteDataIn;
   logic        ClintWriteEnableIn;
   logic [11:0] ClintWriteAddrIn;
   logic [63:0] ClintWriteDataIn;
   logic        InstRetireIn;
   logic        TimerIntIn;
   logic [63:0] CsrMstatusReadDataOut;
   logic [63:0] CsrMtvecReadDataOut;
   logic [63:0] CsrMepcReadDataOut;
   logic [63:0] CsrMieReadDataOut;
   logic [63:0] CsrMipReadDataOut;
   logic        IntAppearOut;
   logic [5:0]  IntFlagOut;

   int totalChecks = 0;
   int badChecks   = 0;
   bit modelValid  = 0;

   logic [63:0] csrModel [logic [11:0]];

   csr_regfile #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
      .Clk(Clk), .Rst(Rst),
      .CsrReadEnableIn(CsrReadEnableIn), .CsrReadAddrIn(CsrReadAddrIn),
      .CsrReadDataOut(CsrReadDataOut), .IllegalCsrOut(IllegalCsrOut),
      .CsrWriteEnableIn(CsrWriteEnableIn), .CsrWriteAddrIn(CsrWriteAddrIn),
      .CsrWriteDataIn(CsrWriteDataIn),
      .ClintWriteEnableIn(ClintWriteEnableIn), .ClintWriteAddrIn(ClintWriteAddrIn),
      .ClintWriteDataIn(ClintWriteDataIn),
      .InstRetireIn(InstRetireIn), .TimerIntIn(TimerIntIn),
      .CsrMstatusReadDataOut(CsrMstatusReadDataOut), .CsrMtvecReadDataOut(CsrMtvecReadDataOut),
      .CsrMepcReadDataOut(CsrMepcReadDataOut), .CsrMieReadDataOut(CsrMieReadDataOut),
      .CsrMipReadDataOut(CsrMipReadDataOut),
      .IntAppearOut(IntAppearOut), .IntFlagOut(IntFlagOut)
   );

   // Free-running 10 ns clock.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Hard time limit so a stuck run still reports.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit isImpl(input logic [11:0] a);
      return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                       12'h344, 12'hB00, 12'hB02, 12'hF14};
   endfunction

   function automatic bit isWritable(input logic [11:0] a);
      return isImpl(a) && (a != 12'hF14) && (a != 12'h344);
   endfunction

   function automatic logic [63:0] legalize(input logic [11:0] a, input logic [63:0] d);
      case (a)
         12'h300:          return d & 64'h88;
         12'h304:          return d & 64'h80;
         12'h305, 12'h341: return {d[63:2], 2'b00};
         default:          return d;
      endcase
   endfunction

   function automatic logic [63:0] modelRead(input logic [11:0] a);
      if (!isImpl(a)) return 64'h0;
      if (a == 12'hF14) return HART_ID;
      return csrModel[a];
   endfunction

   function automatic logic [63:0] modelReadPort();
      if (CsrWriteEnableIn && CsrWriteAddrIn == CsrReadAddrIn && isWritable(CsrReadAddrIn))
         return legalize(CsrReadAddrIn, CsrWriteDataIn);
      return modelRead(CsrReadAddrIn);
   endfunction

   task automatic modelReset();
      csrModel.delete();
      foreach (csrModel[k]) csrModel[k] = 64'h0;
      csrModel[12'h300] = 64'h0; csrModel[12'h304] = 64'h0; csrModel[12'h305] = MTVEC_RST;
      csrModel[12'h340] = 64'h0; csrModel[12'h341] = 64'h0; csrModel[12'h342] = 64'h0;
      csrModel[12'h344] = 64'h0; csrModel[12'hB00] = 64'h0; csrModel[12'hB02] = 64'h0;
   endtask

   // One clock of the reference: counters step, writes override, Clint wins collisions.
   task automatic modelStep();
      logic [63:0] nxt [logic [11:0]];
      bit mtip;
      if (!Rst) begin
         modelReset();
         return;
      end
      nxt = csrModel;
      nxt[12'hB00] = csrModel[12'hB00] + 64'd1;
      if (InstRetireIn) nxt[12'hB02] = csrModel[12'hB02] + 64'd1;
      if (CsrWriteEnableIn && isWritable(CsrWriteAddrIn) &&
          !(ClintWriteEnableIn && ClintWriteAddrIn == CsrWriteAddrIn))
         nxt[CsrWriteAddrIn] = legalize(CsrWriteAddrIn, CsrWriteDataIn);
      if (ClintWriteEnableIn && isWritable(ClintWriteAddrIn))
         nxt[ClintWriteAddrIn] = legalize(ClintWriteAddrIn, ClintWriteDataIn);
      mtip = TimerIntIn || (ClintWriteEnableIn && ClintWriteAddrIn == 12'h344 && ClintWriteDataIn[7]);
      nxt[12'h344] = mtip ? 64'h80 : 64'h0;
      csrModel = nxt;
      modelValid = 1;
   endtask

   task automatic applyStimulus(input bit pwe, input logic [11:0] pa, input logic [63:0] pd,
                                input bit cwe, input logic [11:0] ca, input logic [63:0] cd,
                                input bit re, input logic [11:0] ra,
                                input bit retire, input bit timer);
      CsrWriteEnableIn   = pwe; CsrWriteAddrIn   = pa; CsrWriteDataIn   = pd;
      ClintWriteEnableIn = cwe; ClintWriteAddrIn = ca; ClintWriteDataIn = cd;
      CsrReadEnableIn    = re;  CsrReadAddrIn    = ra;
      InstRetireIn       = retire;
      TimerIntIn         = timer;
   endtask

   // Compares all outputs against the model, then advances one clock (entered and left at negedge).
   task automatic doCycle();
      bit pending;
      #1;
      if (modelValid) begin
         pending = csrModel[12'h344][7] && csrModel[12'h304][7];
         checkOutput("rdData", CsrReadDataOut, modelReadPort());
         checkOutput("illegal", {63'h0, IllegalCsrOut}, {63'h0, CsrReadEnableIn && !isImpl(CsrReadAddrIn)});
         checkOutput("mstatus", CsrMstatusReadDataOut, csrModel[12'h300]);
         checkOutput("mtvec", CsrMtvecReadDataOut, csrModel[12'h305]);
         checkOutput("mepc", CsrMepcReadDataOut, csrModel[12'h341]);
         checkOutput("mie", CsrMieReadDataOut, csrModel[12'h304]);
         checkOutput("mip", CsrMipReadDataOut, csrModel[12'h344]);
         checkOutput("intAppear", {63'h0, IntAppearOut}, {63'h0, pending});
         checkOutput("intFlag", {58'h0, IntFlagOut}, pending ? 64'h8 : 64'h0);
      end
      @(posedge Clk);
      modelStep();
      @(negedge Clk);
   endtask

   task automatic idle();
      applyStimulus(0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0, 12'h0, 0, 0);
   endtask

   logic [11:0] addrPool [12];
   logic [11:0] pa, ca, ra;
   logic [63:0] pd, cd;

   function automatic logic [11:0] pickAddr();
      if ($urandom_range(0, 9) == 0) return 12'($urandom);
      return addrPool[$urandom_range(0, 11)];
   endfunction

   function automatic logic [63:0] pickData();
      if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
      return {$urandom, $urandom};
   endfunction

   initial begin
      addrPool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                   12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'hC00};
      Rst = 1'b0;
      idle();
      @(negedge Clk);

      // Reset state
      doCycle();
      doCycle();
      checkOutput("rst_mtvec", CsrMtvecReadDataOut, MTVEC_RST);
      checkOutput("rst_mstatus", CsrMstatusReadDataOut, 64'h0);
      checkOutput("rst_mepc", CsrMepcReadDataOut, 64'h0);
      checkOutput("rst_mie", CsrMieReadDataOut, 64'h0);
      checkOutput("rst_mip", CsrMipReadDataOut, 64'h0);
      checkOutput("rst_intAppear", {63'h0, IntAppearOut}, 64'h0);
      checkOutput("rst_intFlag", {58'h0, IntFlagOut}, 64'h0);

      // mcycle counts 1,2,3 after release
      Rst = 1'b1;
      applyStimulus(0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 1, 12'hB00, 0, 0);
      doCycle();
      #1 checkOutput("mcycle1", CsrReadDataOut, 64'd1);
      doCycle();
      #1 checkOutput("mcycle2", CsrReadDataOut, 64'd2);
      doCycle();
      #1 checkOutput("mcycle3", CsrReadDataOut, 64'd3);

      // Trap sequence from the controller
      applyStimulus(0, 12'h0, 64'h0, 1, 12'h341, 64'h8000_0104, 0, 12'h0, 0, 0);
      doCycle();
      checkOutput("trap_mepc", CsrMepcReadDataOut, 64'h8000_0104);
      applyStimulus(0, 12'h0, 64'h0, 1, 12'h342, 64'h7, 0, 12'h0, 0, 0);
      doCycle();
      applyStimulus(0, 12'h0, 64'h0, 1, 12'h300, 64'h80, 1, 12'h342, 0, 0);
      #1 checkOutput("trap_mcause", CsrReadDataOut, 64'h7);
      doCycle();
      checkOutput("trap_mstatus", CsrMstatusReadDataOut, 64'h80);

      // Collision: Clint wins
      applyStimulus(1, 12'h300, 64'h8, 0, 12'h0, 64'h0, 0, 12'h0, 0, 0);
      doCycle();
      checkOutput("pipe_mstatus", CsrMstatusReadDataOut, 64'h8);
      applyStimulus(1, 12'h300, 64'h8, 1, 12'h300, 64'h80, 0, 12'h0, 0, 0);
      doCycle();
      checkOutput("collide_mstatus", CsrMstatusReadDataOut, 64'h80);

      // Read forwarding, mhartid, illegal read
      applyStimulus(1, 12'h340, 64'hDEAD, 0, 12'h0, 64'h0, 1, 12'h340, 0, 0);
      #1 checkOutput("fwd_mscratch", CsrReadDataOut, 64'hDEAD);
      doCycle();
      applyStimulus(0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 1, 12'hF14, 0, 0);
      #1 checkOutput("hartid", CsrReadDataOut, HART_ID);
      doCycle();
      applyStimulus(0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 1, 12'h7C0, 0, 0);
      #1 checkOutput("illegal_flag", {63'h0, IllegalCsrOut}, 64'h1);
      checkOutput("illegal_data", CsrReadDataOut, 64'h0);
      doCycle();

      // Timer interrupt rise and fall
      applyStimulus(1, 12'h304, 64'h80, 0, 12'h0, 64'h0, 0, 12'h0, 0, 0);
      doCycle();
      applyStimulus(0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0, 12'h0, 0, 1);
      doCycle();
      checkOutput("timer_appear", {63'h0, IntAppearOut}, 64'h1);
      checkOutput("timer_flag", {58'h0, IntFlagOut}, 64'h8);
      TimerIntIn = 1'b0;
      doCycle();
      checkOutput("timer_drop_appear", {63'h0, IntAppearOut}, 64'h0);
      checkOutput("timer_drop_flag", {58'h0, IntFlagOut}, 64'h0);

      // Counter wrap and write-over-increment
      applyStimulus(1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 12'h0, 64'h0, 0, 12'h0, 0, 0);
      doCycle();
      idle();
      doCycle();
      CsrReadEnableIn = 1'b1; CsrReadAddrIn = 12'hB00;
      #1 checkOutput("mcycle_wrap", CsrReadDataOut, 64'h0);
      applyStimulus(1, 12'hB02, 64'h5, 0, 12'h0, 64'h0, 0, 12'h0, 1, 0);
      doCycle();
      idle();
      CsrReadEnableIn = 1'b1; CsrReadAddrIn = 12'hB02;
      #1 checkOutput("minstret_prio", CsrReadDataOut, 64'h5);
      doCycle();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         pa = pickAddr(); ca = ($urandom_range(0, 3) == 0) ? pa : pickAddr();
         ra = ($urandom_range(0, 2) == 0) ? pa : pickAddr();
         pd = pickData(); cd = pickData();
         applyStimulus(1'($urandom_range(0, 1)), pa, pd, 1'($urandom_range(0, 1)), ca, cd,
                       1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) == 0));
         Rst = ($urandom_range(0, 59) != 0);
         doCycle();
      end
      Rst = 1'b1;
      idle();
      doCycle();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
